// File: rtl/flow_pkg.sv
// Shared types and the flow-table lookup for the 2-input/2-state asynchronous circuit.
package flow_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2,
    OSC    = 2'd3
  } state_e;

  localparam logic [1:0] Y_RESET = 2'b00;

  typedef struct packed {
    logic [1:0] ny;
    logic       z;
  } flow_res_t;

  // Full flow table f(x,y) -> (ny,z); z is only meaningful where ny == y.
  function automatic flow_res_t flow_lookup(input logic [1:0] x, input logic [1:0] y);
    flow_res_t r;
    case ({x, y})
      4'b00_00: r = {2'b00, 1'b0};
      4'b00_01: r = {2'b11, 1'b0};
      4'b00_10: r = {2'b00, 1'b0};
      4'b00_11: r = {2'b11, 1'b0};
      4'b01_00: r = {2'b01, 1'b0};
      4'b01_01: r = {2'b01, 1'b0};
      4'b01_10: r = {2'b01, 1'b1};
      4'b01_11: r = {2'b01, 1'b0};
      4'b11_00: r = {2'b01, 1'b0};
      4'b11_01: r = {2'b01, 1'b0};
      4'b11_10: r = {2'b11, 1'b1};
      4'b11_11: r = {2'b11, 1'b0};
      4'b10_00: r = {2'b00, 1'b0};
      4'b10_01: r = {2'b11, 1'b0};
      4'b10_10: r = {2'b10, 1'b1};
      4'b10_11: r = {2'b10, 1'b0};
      default:  r = {y, 1'b0};
    endcase
    return r;
  endfunction

  function automatic logic [1:0] flow_ny(input logic [1:0] x, input logic [1:0] y);
    flow_res_t t;
    t = flow_lookup(x, y);
    return t.ny;
  endfunction

endpackage

// File: rtl/flow_table_eval.sv
// Combinational flow-table evaluation, plus a look-ahead flag telling whether
// the next secondary state is itself stable under the same input.
module flow_table_eval
  import flow_pkg::*;
(
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic [1:0] ny_o,
  output logic       z_o,
  output logic       ny_stable_o
);

  flow_res_t cur;

  always_comb begin
    cur         = flow_lookup(x_i, y_i);
    ny_o        = cur.ny;
    z_o         = cur.z;
    ny_stable_o = (flow_ny(x_i, cur.ny) == cur.ny);
  end

endmodule

// File: rtl/async_flow_stepper.sv
// Steps the flow-table circuit one transition per clock from a latched input
// until the total state is stable, reporting step count, z and oscillation.
module async_flow_stepper
  import flow_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 4,
  parameter int unsigned STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        x_in,
  output logic              busy,
  output logic              done,
  output logic [1:0]        y_out,
  output logic              z_out,
  output logic [STEP_W-1:0] steps,
  output logic              osc_err
);

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  state_e            state_q, state_d;
  logic [1:0]        x_q, x_d;
  logic [1:0]        y_q, y_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              z_q, z_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              osc_q, osc_d;

  logic [1:0]        ev_ny;
  logic              ev_z;
  logic              ev_ny_stable;
  logic [STEP_W-1:0] steps_inc;

  flow_table_eval u_eval (
    .x_i         (x_q),
    .y_i         (y_q),
    .ny_o        (ev_ny),
    .z_o         (ev_z),
    .ny_stable_o (ev_ny_stable)
  );

  assign steps_inc = steps_q + STEP_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE: begin
        if (ev_ny == y_q)                              state_d = DONE;
        else if ((steps_inc == MAX_CNT) && !ev_ny_stable) state_d = OSC;
      end
      DONE:    state_d = IDLE;
      OSC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    steps_d = steps_q;
    z_d     = z_q;
    osc_d   = osc_q;
    busy_d  = (state_d == SETTLE);
    done_d  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          steps_d = '0;
          osc_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (ev_ny == y_q) begin
          z_d = ev_z;
        end else begin
          y_d = ev_ny;
          if (steps_q != MAX_CNT) steps_d = steps_inc;
        end
      end
      OSC:     osc_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= 2'b00;
      y_q     <= Y_RESET;
      steps_q <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      osc_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      steps_q <= steps_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      osc_q   <= osc_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign y_out   = y_q;
  assign z_out   = z_q;
  assign steps   = steps_q;
  assign osc_err = osc_q;

endmodule

// File: tb/tb_async_flow_stepper.sv
// Scoreboard bench: a reference flow-table model predicts each run's outcome.
module tb_async_flow_stepper;

  localparam int unsigned STEP_W = 3;
  localparam int unsigned MAX_A  = 4;
  localparam int unsigned MAX_B  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_a, start_b;
  logic [1:0]        x_a, x_b;
  logic              busy_a, busy_b, done_a, done_b, z_a, z_b, osc_a, osc_b;
  logic [1:0]        y_a, y_b;
  logic [STEP_W-1:0] steps_a, steps_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] y;
    logic [2:0] steps;
    logic       z;
    logic       osc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] ya_m, yb_m;
  logic       za_m, zb_m;

  always #5 clk = ~clk;

  async_flow_stepper #(.MAX_STEPS(MAX_A), .STEP_W(STEP_W)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x_in(x_a), .busy(busy_a), .done(done_a),
    .y_out(y_a), .z_out(z_a), .steps(steps_a), .osc_err(osc_a)
  );

  async_flow_stepper #(.MAX_STEPS(MAX_B), .STEP_W(STEP_W)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x_in(x_b), .busy(busy_b), .done(done_b),
    .y_out(y_b), .z_out(z_b), .steps(steps_b), .osc_err(osc_b)
  );

  // Reference table, returns {ny, z}
  function automatic logic [2:0] ref_f(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] t00[4], t01[4], t11[4], t10[4];
    t00 = '{3'b000, 3'b110, 3'b000, 3'b110};
    t01 = '{3'b010, 3'b010, 3'b011, 3'b010};
    t11 = '{3'b010, 3'b010, 3'b111, 3'b110};
    t10 = '{3'b000, 3'b110, 3'b101, 3'b100};
    case (x)
      2'b00:   return t00[y];
      2'b01:   return t01[y];
      2'b11:   return t11[y];
      default: return t10[y];
    endcase
  endfunction

  function automatic exp_t model_run(input logic [1:0] x, input logic [1:0] y0,
                                     input logic z0, input int unsigned max);
    exp_t       r;
    logic [1:0] y;
    logic [2:0] f, g;
    int         s;
    y = y0; s = 0; r.osc = 1'b0; r.z = z0;
    for (int i = 0; i < 16; i++) begin
      f = ref_f(x, y);
      if (f[2:1] == y) begin
        r.z = f[0];
        break;
      end
      y = f[2:1];
      s++;
      g = ref_f(x, y);
      if (s == int'(max) && g[2:1] != y) begin
        r.osc = 1'b1;
        break;
      end
    end
    r.y = y;
    r.steps = 3'(s);
    r.lat = r.osc ? s + 1 : s + 2;
    return r;
  endfunction

  task automatic run_a(input logic [1:0] x, input string name, input bit glitch);
    exp_t e, got;
    int   lat;
    bit   seen;
    e = model_run(x, ya_m, za_m, MAX_A);
    sb.push_back(e);
    ya_m = e.y; za_m = e.z;
    @(negedge clk);
    start_a = 1'b1; x_a = x;
    @(posedge clk); #1;
    start_a = 1'b0; x_a = ~x;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy_a); end
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      start_a = (glitch && lat == 1);
      @(posedge clk); #1;
      lat++;
      if (done_a === 1'b1) seen = 1;
    end
    start_a = 1'b0;
    got = sb.pop_front();
    checks++;
    if (!seen || lat != got.lat) begin errors++; $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, lat, seen, got.lat); end
    checks++;
    if (steps_a !== got.steps) begin errors++; $display("FAIL %s steps: got %0d expected %0d", name, steps_a, got.steps); end
    checks++;
    if (z_a !== got.z) begin errors++; $display("FAIL %s z_out: got %b expected %b", name, z_a, got.z); end
    checks++;
    if (y_a !== got.y) begin errors++; $display("FAIL %s y_out: got %b expected %b", name, y_a, got.y); end
    checks++;
    if (busy_a !== 1'b0 || osc_a !== got.osc) begin errors++; $display("FAIL %s busy/osc at done: got %b/%b expected 0/%b", name, busy_a, osc_a, got.osc); end
    if (glitch) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL %s extra_run: got done=%b busy=%b expected 0/0", name, done_a, busy_a); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 0; start_b = 0; x_a = 2'b00; x_b = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, y_a, z_a, steps_a, osc_a} !== 9'b0) begin
      errors++; $display("FAIL reset_a: got busy=%b done=%b y=%b z=%b steps=%0d osc=%b expected all 0", busy_a, done_a, y_a, z_a, steps_a, osc_a);
    end
    checks++;
    if ({busy_b, done_b, y_b, z_b, steps_b, osc_b} !== 9'b0) begin
      errors++; $display("FAIL reset_b: got busy=%b done=%b y=%b z=%b steps=%0d osc=%b expected all 0", busy_b, done_b, y_b, z_b, steps_b, osc_b);
    end
    @(negedge clk); rst = 1'b0;
    ya_m = 2'b00; za_m = 1'b0; yb_m = 2'b00; zb_m = 1'b0;
  endtask

  task automatic test_settle();
    run_a(2'b01, "one_step", 0);
    run_a(2'b10, "two_step", 0);
    run_a(2'b00, "back_to_zero", 0);
    run_a(2'b00, "zero_step", 0);
  endtask

  task automatic test_start_ignored();
    run_a(2'b01, "prep_y01", 0);
    run_a(2'b10, "start_in_settle", 1);
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    start_a = 1'b1; x_a = 2'b00;
    @(posedge clk); #1;
    start_a = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, y_a, z_a, steps_a, osc_a} !== 9'b0) begin
      errors++; $display("FAIL rst_mid_run: got busy=%b done=%b y=%b z=%b steps=%0d osc=%b expected all 0", busy_a, done_a, y_a, z_a, steps_a, osc_a);
    end
    ya_m = 2'b00; za_m = 1'b0; yb_m = 2'b00; zb_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b/%b expected 0/0", done_a, done_b); end
    end
    run_a(2'b01, "after_rst", 0);
  endtask

  task automatic test_osc();
    logic [1:0] xs[3];
    exp_t       e, got;
    int         lat;
    bit         seen_done, seen_osc;
    xs = '{2'b01, 2'b10, 2'b10};
    for (int r = 0; r < 3; r++) begin
      e = model_run(xs[r], yb_m, zb_m, MAX_B);
      sb.push_back(e);
      yb_m = e.y; zb_m = e.z;
      @(negedge clk);
      start_b = 1'b1; x_b = xs[r];
      @(posedge clk); #1;
      start_b = 1'b0;
      lat = 0; seen_done = 0; seen_osc = 0;
      while (!seen_done && !seen_osc && lat < 20) begin
        @(posedge clk); #1;
        lat++;
        seen_done = (done_b === 1'b1);
        seen_osc  = (osc_b === 1'b1);
      end
      got = sb.pop_front();
      checks++;
      if (seen_osc !== got.osc || seen_done === got.osc || lat != got.lat) begin
        errors++; $display("FAIL osc_run%0d outcome: got done=%b osc=%b lat=%0d expected osc=%b lat=%0d", r, seen_done, seen_osc, lat, got.osc, got.lat);
      end
      checks++;
      if (y_b !== got.y || steps_b !== got.steps || z_b !== got.z || busy_b !== 1'b0) begin
        errors++; $display("FAIL osc_run%0d state: got y=%b steps=%0d z=%b busy=%b expected y=%b steps=%0d z=%b busy=0", r, y_b, steps_b, z_b, busy_b, got.y, got.steps, got.z);
      end
      if (got.osc) begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          checks++;
          if (done_b !== 1'b0 || osc_b !== 1'b1) begin errors++; $display("FAIL osc_sticky: got done=%b osc=%b expected 0/1", done_b, osc_b); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] x;
    for (int i = 0; i < 12; i++) begin
      x = 2'($urandom_range(0, 3));
      run_a(x, $sformatf("b2b%0d", i), 0);
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_start_ignored();
    test_osc();
    test_rst_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
